// File: rtl/a1_5_mux4_if.sv
// rtl/a1_5_mux4_if.sv - data/select and result bundle for the a1_5_mux4 equivalence block.
// A1_5_CHECK_EN adds the mismatch and err_cnt checker signals.
interface a1_5_mux4_if #(
    parameter int CNT_W = 8
);
    logic [3:0] d;
    logic [1:0] s;
    logic       y1;
    logic       y0;
    logic       q1;
    logic       q0;
`ifdef A1_5_CHECK_EN
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;
`endif

    modport master (
        output d,
        output s,
        input  y1,
        input  y0,
        input  q1,
        input  q0
`ifdef A1_5_CHECK_EN
        ,
        input  mismatch,
        input  err_cnt
`endif
    );

    modport slave (
        input  d,
        input  s,
        output y1,
        output y0,
        output q1,
        output q0
`ifdef A1_5_CHECK_EN
        ,
        output mismatch,
        output err_cnt
`endif
    );
endinterface

// File: rtl/a1_5_mux4.sv
// rtl/a1_5_mux4.sv - 4:1 mux built as a ternary (y1) and as a 2:1 mux tree (y0), with registered copies.
// A1_5_CHECK_EN enables the registered y1/y0 comparator and saturating mismatch counter.
module a1_5_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module a1_5_mux4 #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    a1_5_mux4_if.slave     bus
);
    logic y1_w;
    logic y0_w;
    logic m0_w;
    logic m1_w;
    logic q1_q;
    logic q0_q;

    assign y1_w = bus.s[1] ? (bus.s[0] ? bus.d[3] : bus.d[2])
                           : (bus.s[0] ? bus.d[1] : bus.d[0]);

    a1_5_mux2 u_mux_lo  (.a(bus.d[0]), .b(bus.d[1]), .sel(bus.s[0]), .y(m0_w));
    a1_5_mux2 u_mux_hi  (.a(bus.d[2]), .b(bus.d[3]), .sel(bus.s[0]), .y(m1_w));
    a1_5_mux2 u_mux_top (.a(m0_w),     .b(m1_w),     .sel(bus.s[1]), .y(y0_w));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q0_q <= 1'b0;
        end else begin
            q1_q <= y1_w;
            q0_q <= y0_w;
        end
    end

    assign bus.y1 = y1_w;
    assign bus.y0 = y0_w;
    assign bus.q1 = q1_q;
    assign bus.q0 = q0_q;

`ifdef A1_5_CHECK_EN
    logic             mismatch_q;
    logic             mismatch_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Counter holds at all-ones rather than wrapping so a long fault stays visible.
    always_comb begin
        mismatch_d = (y1_w !== y0_w) ? 1'b1 : 1'b0;
        err_cnt_d  = err_cnt_q;
        if ((y1_w != y0_w) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
`endif
endmodule

// File: tb/tb_a1_5_mux4.sv
// tb/tb_a1_5_mux4.sv - self-checking bench for a1_5_mux4 (checker probes guarded by A1_5_CHECK_EN).
module tb_a1_5_mux4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a1_5_mux4_if #(.CNT_W(CNT_W)) bus ();
    a1_5_mux4 #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0] s;
        logic [3:0] d;
        logic       y;
    } vec_t;

    vec_t tbl[4];
    logic comb_exp[$];
    logic reg_exp[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic ref_mux(input logic [1:0] s, input logic [3:0] d);
        case (s)
            2'b00:   return d[0];
            2'b01:   return d[1];
            2'b10:   return d[2];
            default: return d[3];
        endcase
    endfunction

    task automatic comb_vec(input logic [1:0] s, input logic [3:0] d, input logic y, input string name);
        logic e;
        bus.s = s;
        bus.d = d;
        comb_exp.push_back(y);
        #1;
        if (comb_exp.size() == 0) begin
            chk({name, "_queue"}, 0, 1);
        end else begin
            e = comb_exp.pop_front();
            chk({name, "_y1"}, 32'(bus.y1), 32'(e));
            chk({name, "_y0"}, 32'(bus.y0), 32'(e));
        end
`ifdef A1_5_CHECK_EN
        chk({name, "_mismatch"}, 32'(bus.mismatch), 0);
`endif
        #4;
    endtask

    task automatic clk_step(input logic [1:0] s, input logic [3:0] d, input logic rst, input logic q, input string name);
        logic e;
        @(negedge clk);
        bus.s = s;
        bus.d = d;
        rst_n = rst;
        reg_exp.push_back(q);
        @(posedge clk);
        #1;
        e = reg_exp.pop_front();
        chk({name, "_q1"}, 32'(bus.q1), 32'(e));
        chk({name, "_q0"}, 32'(bus.q0), 32'(e));
    endtask

    initial begin
        logic [5:0] r;
        tbl[0] = '{s: 2'b00, d: 4'b0001, y: 1'b1};
        tbl[1] = '{s: 2'b01, d: 4'b0001, y: 1'b0};
        tbl[2] = '{s: 2'b11, d: 4'b1000, y: 1'b1};
        tbl[3] = '{s: 2'b10, d: 4'b1011, y: 1'b0};

        bus.s = 2'b10;
        bus.d = 4'b0100;
        clk_step(2'b10, 4'b0100, 1'b0, 1'b0, "reset");
`ifdef A1_5_CHECK_EN
        chk("reset_mismatch", 32'(bus.mismatch), 0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) comb_vec(tbl[i].s, tbl[i].d, tbl[i].y, $sformatf("tbl%0d", i));

        for (int i = 0; i < 64; i++) begin
            r = 6'(i);
            comb_vec(r[5:4], r[3:0], ref_mux(r[5:4], r[3:0]), $sformatf("sweep%0d", i));
        end
`ifdef A1_5_CHECK_EN
        chk("sweep_err_cnt", 32'(bus.err_cnt), 0);
`endif

        for (int i = 0; i < 30; i++) begin
            r = 6'($urandom_range(0, 63));
            $display("t=%0t s=%b d=%b", $time, r[5:4], r[3:0]);
            comb_vec(r[5:4], r[3:0], ref_mux(r[5:4], r[3:0]), $sformatf("rand%0d", i));
        end

        clk_step(2'b10, 4'b0100, 1'b1, 1'b1, "cap");
        clk_step(2'b10, 4'b0100, 1'b0, 1'b0, "midrst");
`ifdef A1_5_CHECK_EN
        chk("midrst_err_cnt", 32'(bus.err_cnt), 0);
`endif
        clk_step(2'b10, 4'b0100, 1'b1, 1'b1, "release");
        clk_step(2'b01, 4'b1101, 1'b1, 1'b0, "cap_s01");
        clk_step(2'b11, 4'b1000, 1'b1, 1'b1, "cap_s11");

        // Reset pulse that never spans a rising edge must leave the registers alone.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("glitch_q1", 32'(bus.q1), 1);
        chk("glitch_q0", 32'(bus.q0), 1);

`ifdef A1_5_CHECK_EN
        @(negedge clk);
        bus.s = 2'b00;
        bus.d = 4'b0001;
        force dut.y0_w = 1'b0;
        @(posedge clk);
        #1;
        chk("force_first_err_cnt", 32'(bus.err_cnt), 1);
        repeat (299) @(posedge clk);
        #1;
        chk("force_mismatch", 32'(bus.mismatch), 1);
        chk("force_err_cnt_sat", 32'(bus.err_cnt), 255);
        chk("force_q0", 32'(bus.q0), 0);
        chk("force_q1", 32'(bus.q1), 1);
        release dut.y0_w;
        clk_step(2'b00, 4'b0001, 1'b0, 1'b0, "post_force_rst");
        chk("post_force_err_cnt", 32'(bus.err_cnt), 0);
        chk("post_force_mismatch", 32'(bus.mismatch), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
